// File: rtl/fixed_point_mac_if.sv
// Beat and result handshake bundle for fixed_point_mac.
// master drives operands and result-ready; slave is the MAC.
interface fixed_point_mac_if #(
    parameter int W = 33
);
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         valid_in;
    logic         last_in;
    logic         ready_out;
    logic [W-1:0] y_out;
    logic         valid_out;
    logic         ready_in;
    logic         overflow_out;

    modport master (
        output a_in, b_in, valid_in, last_in, ready_in,
        input  ready_out, y_out, valid_out, overflow_out
    );

    modport slave (
        input  a_in, b_in, valid_in, last_in, ready_in,
        output ready_out, y_out, valid_out, overflow_out
    );
endinterface

// File: rtl/fixed_point_mac.sv
// Streaming sign-magnitude fixed-point MAC with saturated dot-product output.
// Optional FXP_MAC_ROUND_EN: round-half-up product magnitude instead of truncating.
module fixed_point_mac #(
    parameter int sign      = 1,
    parameter int q_m       = 16,
    parameter int q_n       = 16,
    parameter int ACC_GUARD = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    fixed_point_mac_if.slave bus
);
    localparam int MW = q_m + q_n;
    localparam int W  = sign + MW;
    localparam int FW = 2 * MW;
    localparam int PW = 2 * q_m + q_n;
    localparam int AW = PW + 1 + ACC_GUARD;

    logic          w_stall;
    logic          w_take;
    logic [MW-1:0] w_a_mag;
    logic [MW-1:0] w_b_mag;
    logic [FW-1:0] w_full;
    logic [FW-1:0] w_rnd;
    logic [PW-1:0] w_pmag;
    logic          w_psign;

    logic          r_p_valid;
    logic          r_p_last;
    logic          r_p_sign;
    logic [PW-1:0] r_p_mag;

    logic [AW-1:0] r_acc;
    logic          r_first;
    logic [AW-1:0] w_ext;
    logic [AW-1:0] w_term;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_acc_next;
    logic [AW-1:0] w_abs;
    logic          w_neg;
    logic          w_ovf;
    logic [MW-1:0] w_mag;
    logic          w_ysign;

    logic [W-1:0]  r_y;
    logic          r_ovf;
    logic          r_vout;

    assign w_stall       = r_vout && !bus.ready_in;
    assign w_take        = bus.valid_in && !w_stall;
    assign bus.ready_out = !w_stall;

    assign w_a_mag = bus.a_in[MW-1:0];
    assign w_b_mag = bus.b_in[MW-1:0];
    assign w_full  = FW'(w_a_mag) * FW'(w_b_mag);

`ifdef FXP_MAC_ROUND_EN
    assign w_rnd = w_full + (FW'(1) << (q_n - 1));
`else
    assign w_rnd = w_full;
`endif

    assign w_pmag  = w_rnd[FW-1:q_n];
    assign w_psign = (bus.a_in[W-1] ^ bus.b_in[W-1]) && (|w_pmag);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
            r_p_sign  <= 1'b0;
            r_p_mag   <= '0;
        end else if (!w_stall) begin
            r_p_valid <= w_take;
            if (w_take) begin
                r_p_last <= bus.last_in;
                r_p_sign <= w_psign;
                r_p_mag  <= w_pmag;
            end
        end
    end

    assign w_ext      = AW'(r_p_mag);
    assign w_term     = r_p_sign ? -w_ext : w_ext;
    assign w_base     = r_first ? '0 : r_acc;
    assign w_acc_next = w_base + w_term;

    // Saturate on the absolute value so both signs clip to full-scale magnitude.
    assign w_neg   = w_acc_next[AW-1];
    assign w_abs   = w_neg ? -w_acc_next : w_acc_next;
    assign w_ovf   = |w_abs[AW-1:MW];
    assign w_mag   = w_ovf ? '1 : w_abs[MW-1:0];
    assign w_ysign = w_neg && (|w_mag);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_acc   <= '0;
            r_first <= 1'b1;
        end else if (!w_stall && r_p_valid) begin
            r_acc   <= w_acc_next;
            r_first <= r_p_last;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_y    <= '0;
            r_ovf  <= 1'b0;
            r_vout <= 1'b0;
        end else if (!w_stall && r_p_valid && r_p_last) begin
            r_y    <= {w_ysign, w_mag};
            r_ovf  <= w_ovf;
            r_vout <= 1'b1;
        end else if (r_vout && bus.ready_in) begin
            r_vout <= 1'b0;
        end
    end

    assign bus.y_out        = r_y;
    assign bus.overflow_out = r_ovf;
    assign bus.valid_out    = r_vout;
endmodule

// File: tb/tb_fixed_point_mac.sv
// Scoreboard bench for fixed_point_mac: directed Q16.16 cases plus
// randomized packets with random backpressure against an integer model.
module tb_fixed_point_mac;
    logic clk = 1'b0;
    logic reset_i = 1'b1;

    fixed_point_mac_if #(.W(33)) bus ();

    fixed_point_mac dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_out = 0;
    int n_acc = 0;
    logic [32:0] last_y = '0;
    logic        last_ovf = 1'b0;
    logic [33:0] exp_q[$];
    longint      m_acc = 0;
    bit          rand_bp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Product of two sign-magnitude Q16.16 values, in Q.16 integer units.
    function automatic longint term(input logic [32:0] a, input logic [32:0] b);
        longint unsigned p;
        p = 64'(a[31:0]) * 64'(b[31:0]);
`ifdef FXP_MAC_ROUND_EN
        p = p + 64'd32768;
`endif
        p = p >> 16;
        return (a[32] ^ b[32]) ? -longint'(p) : longint'(p);
    endfunction

    function automatic logic [33:0] expect_of(input longint s);
        longint unsigned mag;
        bit ovf;
        logic [31:0] m;
        bit sg;
        mag = (s < 0) ? longint'(-s) : longint'(s);
        ovf = (mag > 64'h0000_0000_FFFF_FFFF);
        m = ovf ? 32'hFFFF_FFFF : mag[31:0];
        sg = (s < 0) && (m != 0);
        return {ovf, sg, m};
    endfunction

    // Presents one beat from a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [32:0] a, input logic [32:0] b, input bit last);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        bus.a_in = a;
        bus.b_in = b;
        bus.last_in = last;
        bus.valid_in = 1'b1;
        while (!done && n < 200) begin
            #4;
            if (bus.ready_out) begin
                done = 1'b1;
                n_acc++;
                m_acc += term(a, b);
                if (last) begin
                    exp_q.push_back(expect_of(m_acc));
                    m_acc = 0;
                end
            end
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat not accepted within %0d cycles", n);
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_out(input int target, input string name);
        int n;
        n = 0;
        while (n_out < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n_out < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: outputs seen %0d expected %0d", name, n_out, target);
        end
    endtask

    initial begin
        bit held;
        logic [32:0] hy;
        logic hovf;
        logic [33:0] e;
        held = 1'b0;
        hy = '0;
        hovf = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (held && bus.valid_out) begin
                chk("hold_y", 64'(bus.y_out), 64'(hy));
                chk("hold_ovf", 64'(bus.overflow_out), 64'(hovf));
            end
            held = bus.valid_out && !bus.ready_in;
            hy = bus.y_out;
            hovf = bus.overflow_out;
            if (!reset_i && bus.valid_out && bus.ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got y=%h ovf=%b", bus.y_out, bus.overflow_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_y", 64'(bus.y_out), 64'(e[32:0]));
                    chk("sb_ovf", 64'(bus.overflow_out), 64'(e[33]));
                end
                last_y = bus.y_out;
                last_ovf = bus.overflow_out;
                n_out++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_bp) bus.ready_in = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [32:0] rnd_op();
        logic [31:0] m;
        int mode;
        mode = $urandom_range(0, 2);
        if (mode == 0) m = $urandom;
        else if (mode == 1) m = $urandom_range(0, 32'h0003_FFFF);
        else m = $urandom_range(0, 32'h0000_FFFF);
        return {1'($urandom_range(0, 1)), m};
    endfunction

    initial begin
        int cnt;
        int acc0;
        int len;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.valid_in = 1'b0;
        bus.last_in = 1'b0;
        bus.ready_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus.valid_out), 64'd0);
        chk("rst_ready", 64'(bus.ready_out), 64'd1);
        chk("rst_y", 64'(bus.y_out), 64'd0);
        chk("rst_ovf", 64'(bus.overflow_out), 64'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // single beat and latency
        cnt = n_out;
        send(33'h0_0000_8000, 33'h0_0000_8000, 1'b1);
        chk("lat_early", 64'(bus.valid_out), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(bus.valid_out), 64'd1);
        wait_out(cnt + 1, "single");
        chk("single_y", 64'(last_y), 64'h0_0000_4000);
        chk("single_ovf", 64'(last_ovf), 64'd0);

        // three-beat packet
        cnt = n_out;
        send(33'h0_0001_8000, 33'h0_0001_8000, 1'b0);
        send(33'h1_0000_8000, 33'h0_0000_8000, 1'b0);
        send(33'h1_0000_8000, 33'h1_0000_8000, 1'b1);
        wait_out(cnt + 1, "three");
        chk("three_y", 64'(last_y), 64'h0_0002_4000);

        // cancellation, no negative zero
        cnt = n_out;
        send(33'h0_0000_8000, 33'h0_0000_8000, 1'b0);
        send(33'h1_0000_8000, 33'h0_0000_8000, 1'b1);
        wait_out(cnt + 1, "cancel");
        chk("cancel_y", 64'(last_y), 64'h0);

        // saturation, both signs, back to back
        cnt = n_out;
        send(33'h0_FFFF_0000, 33'h0_FFFF_0000, 1'b1);
        send(33'h1_FFFF_0000, 33'h0_FFFF_0000, 1'b1);
        wait_out(cnt + 2, "sat");
        chk("sat_neg_y", 64'(last_y), 64'h1_FFFF_FFFF);
        chk("sat_neg_ovf", 64'(last_ovf), 64'd1);

        // backpressure
        cnt = n_out;
        bus.ready_in = 1'b0;
        send(33'h0_0000_8000, 33'h0_0000_8000, 1'b1);
        begin
            int n;
            n = 0;
            while (!bus.valid_out && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("bp_valid", 64'(bus.valid_out), 64'd1);
        acc0 = n_acc;
        fork
            send(33'h0_0000_1F98, 33'h0_0000_1F98, 1'b1);
            begin
                repeat (3) begin
                    chk("bp_ready", 64'(bus.ready_out), 64'd0);
                    chk("bp_y", 64'(bus.y_out), 64'h0_0000_4000);
                    @(negedge clk);
                end
                chk("bp_no_take", 64'(n_acc), 64'(acc0));
                bus.ready_in = 1'b1;
            end
        join
        wait_out(cnt + 2, "bp");
        chk("bp_y_after", 64'(last_y), 64'h0_0000_03E6);

        // reset mid-packet, then a beat that depends on rounding
        cnt = n_out;
        send(33'h0_0003_0000, 33'h0_0002_0000, 1'b0);
        send(33'h0_0001_0000, 33'h0_0001_0000, 1'b0);
        reset_i = 1'b1;
        m_acc = 0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(bus.valid_out), 64'd0);
        chk("mid_rst_ready", 64'(bus.ready_out), 64'd1);
        chk("mid_rst_y", 64'(bus.y_out), 64'd0);
        reset_i = 1'b0;
        send(33'h0_0000_0001, 33'h0_0000_8000, 1'b1);
        wait_out(cnt + 1, "rst");
`ifdef FXP_MAC_ROUND_EN
        chk("rst_round_y", 64'(last_y), 64'h0_0000_0001);
`else
        chk("rst_trunc_y", 64'(last_y), 64'h0_0000_0000);
`endif

        // randomized packets under random backpressure
        rand_bp = 1'b1;
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send(rnd_op(), rnd_op(), k == len - 1);
            end
        end
        rand_bp = 1'b0;
        bus.ready_in = 1'b1;
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
